// File: rtl/avl_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avl_arb_pkg
//  Description : Shared types and constants for the two-master Avalon-style
//                bus arbiter: master identifiers and bus field widths.
//  Revision    : 1.0  initial release
// ============================================================================
package avl_arb_pkg;

    // Bus field widths used by i_avl_bus.
    localparam int AVL_ADDR_W = 32;
    localparam int AVL_DATA_W = 32;
    localparam int AVL_BE_W   = AVL_DATA_W / 8;

    // One bit is enough to name either master.
    typedef logic master_id_t;

    localparam master_id_t M_IFETCH = 1'b0;   // instruction-fetch master
    localparam master_id_t M_DATA   = 1'b1;   // data / load-store master

    // The master that is not 'id'. Used by round-robin to pick the
    // requester that was not served last.
    function automatic master_id_t other_master(input master_id_t id);
        return ~id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avl_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : i_avl_bus
//  Description : Pipelined Avalon-style memory bus. The request phase uses
//                read/write with request_ready as the accept strobe; read
//                data returns later, in order, qualified by read_data_valid.
//                There are no write responses.
//  Ports       : master modport drives address/byte_en/write_data/read/write
//                and samples request_ready/read_data/read_data_valid;
//                slave modport is the mirror image.
//  Revision    : 1.0  initial release
// ============================================================================
interface i_avl_bus;
    import avl_arb_pkg::*;

    logic [AVL_ADDR_W-1:0] address;
    logic [AVL_BE_W-1:0]   byte_en;
    logic [AVL_DATA_W-1:0] write_data;
    logic                  read;
    logic                  write;
    logic                  request_ready;
    logic [AVL_DATA_W-1:0] read_data;
    logic                  read_data_valid;

    modport master (
        output address, byte_en, write_data, read, write,
        input  request_ready, read_data, read_data_valid
    );

    modport slave (
        input  address, byte_en, write_data, read, write,
        output request_ready, read_data, read_data_valid
    );

endinterface
`default_nettype wire

// File: rtl/avl_arb_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : avl_arb_id_fifo
//  Description : Small synchronous FIFO of master IDs, one entry per read in
//                flight. The head entry names the master that owns the next
//                returning read_data_valid.
//  Ports       : clk, rest (async, active-high)
//                push/push_id : enqueue an ID (ignored while full)
//                pop          : dequeue the head (ignored while empty)
//                head_id      : ID at the head
//                full/empty/count : occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module avl_arb_id_fifo
    import avl_arb_pkg::*;
#(
    parameter int DEPTH = 4     // power of two, at least 2
) (
    input  logic                       clk,
    input  logic                       rest,
    input  logic                       push,
    input  master_id_t                 push_id,
    input  logic                       pop,
    output master_id_t                 head_id,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    master_id_t             r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic w_push;
    logic w_pop;

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign head_id = r_mem[r_rd_ptr];

    // Guard against overflow/underflow locally so the counters stay
    // consistent even if a caller misbehaves.
    assign w_push = push & ~full;
    assign w_pop  = pop  & ~empty;

    // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/avl_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : avl_bus_arbiter
//  Description : Two-master to one-slave arbiter. Master 0 is instruction
//                fetch, master 1 is load/store data. The grant is
//                combinational; every accepted read pushes the issuing master
//                ID into a FIFO so in-order read data is steered back to the
//                correct master with zero added latency.
//  Ports       : clk, rest (async, active-high)
//                avl_s0     : slave port facing master 0 (instruction fetch)
//                avl_s1     : slave port facing master 1 (data)
//                avl_m0     : master port to the shared memory slave
//                outstanding: reads currently in flight
//                err_unexpected_rsp : sticky, a response arrived with no read
//                             in flight (expected after a mid-flight reset)
//  Revision    : 1.0  initial release
// ============================================================================
module avl_bus_arbiter
    import avl_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,  // read-ID FIFO depth, power of two >= 2
    parameter int FIXED_PRIO      = 0   // 0: round-robin, 1: master 1 always wins
) (
    input  logic                                 clk,
    input  logic                                 rest,
    i_avl_bus.slave                              avl_s0,
    i_avl_bus.slave                              avl_s1,
    i_avl_bus.master                             avl_m0,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_unexpected_rsp
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // ------------------------------------------------------------------
    // Request detection and grant
    // ------------------------------------------------------------------
    logic       w_req0;
    logic       w_req1;
    logic       w_gnt_vld;
    master_id_t w_gnt_id;
    master_id_t r_rr_last;

    assign w_req0    = avl_s0.read | avl_s0.write;
    assign w_req1    = avl_s1.read | avl_s1.write;
    assign w_gnt_vld = w_req0 | w_req1;

    generate
        if (FIXED_PRIO != 0) begin : g_fixed_prio
            assign w_gnt_id = w_req1 ? M_DATA : M_IFETCH;
        end else begin : g_round_robin
            // On contention serve whoever was not served last; otherwise
            // the sole requester. With no request this resolves to master 0
            // so the forwarded (don't-care) fields come from master 0.
            assign w_gnt_id = (w_req0 && w_req1) ? other_master(r_rr_last)
                                                 : (w_req1 ? M_DATA : M_IFETCH);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request forwarding
    // ------------------------------------------------------------------
    logic [AVL_ADDR_W-1:0] w_sel_addr;
    logic [AVL_BE_W-1:0]   w_sel_be;
    logic [AVL_DATA_W-1:0] w_sel_wdata;
    logic                  w_sel_read;
    logic                  w_sel_write;

    always_comb begin
        w_sel_addr  = avl_s0.address;
        w_sel_be    = avl_s0.byte_en;
        w_sel_wdata = avl_s0.write_data;
        w_sel_read  = avl_s0.read;
        w_sel_write = avl_s0.write;
        if (w_gnt_id == M_DATA) begin
            w_sel_addr  = avl_s1.address;
            w_sel_be    = avl_s1.byte_en;
            w_sel_wdata = avl_s1.write_data;
            w_sel_read  = avl_s1.read;
            w_sel_write = avl_s1.write;
        end
    end

    // ------------------------------------------------------------------
    // Read-ID FIFO
    // ------------------------------------------------------------------
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    master_id_t       w_head_id;
    logic [CNT_W-1:0] w_fifo_count;

    // A read is only launched when a FIFO slot is free at the start of the
    // cycle. A pop in the same cycle does not free the slot early, so the
    // response path never feeds combinationally into request_ready.
    logic w_accept;
    assign w_accept = ~rest & w_gnt_vld & avl_m0.request_ready
                    & (w_sel_write | ~w_fifo_full);

    assign w_push = w_accept & w_sel_read & ~w_fifo_full;
    assign w_pop  = ~rest & avl_m0.read_data_valid & ~w_fifo_empty;

    avl_arb_id_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rest    (rest),
        .push    (w_push),
        .push_id (w_gnt_id),
        .pop     (w_pop),
        .head_id (w_head_id),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Slave-side drive. A stalled read keeps the grant (so the master keeps
    // its turn) but read is withheld from the slave.
    // ------------------------------------------------------------------
    assign avl_m0.address    = w_sel_addr;
    assign avl_m0.byte_en    = w_sel_be;
    assign avl_m0.write_data = w_sel_wdata;
    assign avl_m0.read       = ~rest & w_sel_read & ~w_fifo_full;
    assign avl_m0.write      = ~rest & w_sel_write;

    // ------------------------------------------------------------------
    // Master-side handshake and response routing
    // ------------------------------------------------------------------
    assign avl_s0.request_ready   = w_accept & (w_gnt_id == M_IFETCH);
    assign avl_s1.request_ready   = w_accept & (w_gnt_id == M_DATA);

    assign avl_s0.read_data       = avl_m0.read_data;
    assign avl_s1.read_data       = avl_m0.read_data;
    assign avl_s0.read_data_valid = w_pop & (w_head_id == M_IFETCH);
    assign avl_s1.read_data_valid = w_pop & (w_head_id == M_DATA);

    assign outstanding = w_fifo_count;

    // ------------------------------------------------------------------
    // Round-robin history and error flag
    // ------------------------------------------------------------------
    // Reset to master 1 so master 0 wins the first contention.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_rr_last <= M_DATA;
        end else if (w_accept) begin
            r_rr_last <= w_gnt_id;
        end
    end

    // A response with nothing in flight is dropped and flagged until reset.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            err_unexpected_rsp <= 1'b0;
        end else if (avl_m0.read_data_valid && w_fifo_empty) begin
            err_unexpected_rsp <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avl_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_avl_bus_arbiter
//  Description : Testbench for avl_bus_arbiter. A queue-based memory slave
//                with configurable latency sits on the shared port; master
//                request queues drive both slave ports; an abstract model
//                predicts grants and response ownership, and a separate
//                monitor scores every returned read.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_avl_bus_arbiter;
    import avl_arb_pkg::*;

    localparam int MAXO = 4;

    logic clk  = 1'b0;
    logic rest = 1'b1;
    always #5 clk = ~clk;

    i_avl_bus bus_s0 ();
    i_avl_bus bus_s1 ();
    i_avl_bus bus_m  ();
    i_avl_bus f_s0   ();
    i_avl_bus f_s1   ();
    i_avl_bus f_m    ();

    logic [2:0] outstanding;
    logic [2:0] f_outstanding;
    logic       err;
    logic       f_err;

    avl_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .FIXED_PRIO(0)) dut (
        .clk(clk), .rest(rest), .avl_s0(bus_s0), .avl_s1(bus_s1), .avl_m0(bus_m),
        .outstanding(outstanding), .err_unexpected_rsp(err)
    );

    avl_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rest(rest), .avl_s0(f_s0), .avl_s1(f_s1), .avl_m0(f_m),
        .outstanding(f_outstanding), .err_unexpected_rsp(f_err)
    );

    typedef struct { bit rd; bit wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } op_t;
    typedef struct { bit id; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] d; int t; } rsp_t;

    op_t  mq0[$];
    op_t  mq1[$];
    exp_t exp_q[$];
    rsp_t rsp_q[$];

    logic [31:0] ref_mem [256];
    logic [31:0] slv_mem [256];

    int n_pass = 0;
    int n_chk  = 0;

    int  slv_lat = 1;
    int  slv_ready_pct = 100;
    int  cyc = 0;
    bit  in_reset = 1'b1;
    bit  rr_m = 1'b1;
    int  gseq[$];
    int  n_acc, first_acc, last_acc, max_out, wr_stalls, tcyc, n_drop;
    int  vcnt[2];
    logic [31:0] last_data[2];

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // ---------------- memory slave model ----------------
    bit          a_rd, a_wr, a_pop;
    logic [31:0] a_addr, a_wd;
    logic [3:0]  a_be;
    rsp_t        s_r;

    initial begin
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        bus_m.request_ready = 1'b0; bus_m.read_data = '0; bus_m.read_data_valid = 1'b0;
        f_m.request_ready = 1'b1; f_m.read_data = '0; f_m.read_data_valid = 1'b0;
    end

    always begin
        @(negedge clk);
        a_rd   = bus_m.read  && bus_m.request_ready;
        a_wr   = bus_m.write && bus_m.request_ready;
        a_pop  = bus_m.read_data_valid;
        a_addr = bus_m.address; a_wd = bus_m.write_data; a_be = bus_m.byte_en;
        @(posedge clk); #1;
        cyc++;
        if (a_pop && rsp_q.size() > 0) void'(rsp_q.pop_front());
        if (a_wr) begin
            for (int b = 0; b < 4; b++)
                if (a_be[b]) slv_mem[a_addr[9:2]][8*b +: 8] = a_wd[8*b +: 8];
        end
        if (a_rd) begin
            s_r.d = slv_mem[a_addr[9:2]];
            s_r.t = cyc + slv_lat - 1;
            if (rsp_q.size() > 0 && s_r.t < rsp_q[$].t) s_r.t = rsp_q[$].t;
            rsp_q.push_back(s_r);
        end
        bus_m.read_data_valid = (rsp_q.size() > 0) && (rsp_q[0].t <= cyc);
        bus_m.read_data       = bus_m.read_data_valid ? rsp_q[0].d : 32'h0;
        bus_m.request_ready   = ($urandom_range(99) < 32'(slv_ready_pct));
    end

    // ---------------- response monitor / scoreboard ----------------
    exp_t mon_e;
    always begin
        @(negedge clk); #1;
        if (bus_s0.read_data_valid) vcnt[0]++;
        if (bus_s1.read_data_valid) vcnt[1]++;
        if (in_reset) begin
            check("rst_valid0", bus_s0.read_data_valid, 0);
            check("rst_valid1", bus_s1.read_data_valid, 0);
        end else if (bus_m.read_data_valid) begin
            if (exp_q.size() == 0) begin
                n_drop++;
                check("drop_valid0", bus_s0.read_data_valid, 0);
                check("drop_valid1", bus_s1.read_data_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("route0", bus_s0.read_data_valid, (mon_e.id == 1'b0));
                check("route1", bus_s1.read_data_valid, (mon_e.id == 1'b1));
                check("rdata", mon_e.id ? bus_s1.read_data : bus_s0.read_data, mon_e.data);
                last_data[mon_e.id] = mon_e.id ? bus_s1.read_data : bus_s0.read_data;
            end
        end else begin
            check("idle_valid0", bus_s0.read_data_valid, 0);
            check("idle_valid1", bus_s1.read_data_valid, 0);
        end
    end

    // ---------------- master drive and reference model ----------------
    task automatic drive_heads();
        op_t o;
        o = '{0, 0, 32'h0, 4'h0, 32'h0};
        if (mq0.size() > 0) o = mq0[0];
        bus_s0.read = o.rd; bus_s0.write = o.wr; bus_s0.address = o.addr;
        bus_s0.byte_en = o.be; bus_s0.write_data = o.wd;
        o = '{0, 0, 32'h0, 4'h0, 32'h0};
        if (mq1.size() > 0) o = mq1[0];
        bus_s1.read = o.rd; bus_s1.write = o.wr; bus_s1.address = o.addr;
        bus_s1.byte_en = o.be; bus_s1.write_data = o.wd;
    endtask

    task automatic step();
        bit r0, r1, g, full, acc, d0, d1;
        op_t o;
        exp_t e;
        @(negedge clk);
        tcyc++;
        r0   = mq0.size() > 0 && (mq0[0].rd || mq0[0].wr);
        r1   = mq1.size() > 0 && (mq1[0].rd || mq1[0].wr);
        full = (exp_q.size() >= MAXO);
        g    = (r0 && r1) ? ~rr_m : r1;
        o    = '{0, 0, 32'h0, 4'h0, 32'h0};
        if (g && r1) o = mq1[0];
        else if (!g && r0) o = mq0[0];
        acc = (r0 || r1) && bus_m.request_ready && (o.wr || !full);
        check("outstanding", outstanding, exp_q.size());
        check("ready0", bus_s0.request_ready, acc && !g);
        check("ready1", bus_s1.request_ready, acc && g);
        check("m_read", bus_m.read, o.rd && !full);
        check("m_write", bus_m.write, o.wr);
        if (o.rd || o.wr) check("m_addr", bus_m.address, o.addr);
        if (o.wr) begin
            check("m_wdata", bus_m.write_data, o.wd);
            check("m_be", bus_m.byte_en, o.be);
            if (!acc) wr_stalls++;
        end
        if (int'(outstanding) > max_out) max_out = int'(outstanding);
        if (acc) begin
            rr_m = g;
            n_acc++;
            if (first_acc < 0) first_acc = tcyc;
            last_acc = tcyc;
            gseq.push_back(int'(g));
            if (o.rd) begin
                e.id = g; e.data = ref_mem[o.addr[9:2]];
                exp_q.push_back(e);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (o.be[b]) ref_mem[o.addr[9:2]][8*b +: 8] = o.wd[8*b +: 8];
            end
        end
        d0 = (acc && !g) || (mq0.size() > 0 && !r0);
        d1 = (acc &&  g) || (mq1.size() > 0 && !r1);
        @(posedge clk); #1;
        if (d0) void'(mq0.pop_front());
        if (d1) void'(mq1.pop_front());
        drive_heads();
    endtask

    task automatic run_phase(input string name, input int budget);
        int n = 0;
        drive_heads();
        while ((mq0.size() > 0 || mq1.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic clear_stats();
        n_acc = 0; first_acc = -1; last_acc = -1; max_out = 0; wr_stalls = 0;
        vcnt[0] = 0; vcnt[1] = 0; gseq.delete();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rest = 1'b1; in_reset = 1'b1; rr_m = 1'b1;
        exp_q.delete(); mq0.delete(); mq1.delete();
        bus_s0.read = 1'b1; bus_s0.write = 1'b0; bus_s0.address = 32'h40;
        bus_s1.read = 1'b0; bus_s1.write = 1'b1; bus_s1.address = 32'h44;
        repeat (n) begin
            @(negedge clk);
            check("rst_m_read", bus_m.read, 0);
            check("rst_m_write", bus_m.write, 0);
            check("rst_ready0", bus_s0.request_ready, 0);
            check("rst_ready1", bus_s1.request_ready, 0);
            check("rst_outstanding", outstanding, 0);
        end
        @(posedge clk); #1;
        rest = 1'b0; in_reset = 1'b0;
        drive_heads();
    endtask

    function automatic op_t mk_rd(input logic [31:0] a);
        return '{1, 0, a, 4'hF, 32'h0};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        int  bad, n;
        f_s0.read = 0; f_s0.write = 0; f_s0.address = 0; f_s0.byte_en = 0; f_s0.write_data = 0;
        f_s1.read = 0; f_s1.write = 0; f_s1.address = 0; f_s1.byte_en = 0; f_s1.write_data = 0;
        mq0.delete(); mq1.delete();
        drive_heads();
        clear_stats(); n_drop = 0;

        // Reset state
        do_reset(3);
        @(negedge clk);
        check("reset_outstanding", outstanding, 0);
        check("reset_err", err, 0);
        @(posedge clk); #1;

        // Test 1: master 0 back-to-back reads, 1-cycle latency
        slv_lat = 1; slv_ready_pct = 100; clear_stats();
        mq0.push_back(mk_rd(32'h000)); mq0.push_back(mk_rd(32'h004)); mq0.push_back(mk_rd(32'h008));
        run_phase("t1", 50);
        check("t1_accepts", n_acc, 3);
        check("t1_span", last_acc - first_acc, 2);
        check("t1_valid_m0", vcnt[0], 3);
        check("t1_valid_m1", vcnt[1], 0);
        check("t1_word2", last_data[0], init_word(2));

        // Test 2: both masters read every cycle, round-robin from reset
        do_reset(2); clear_stats();
        for (int i = 0; i < 6; i++) begin
            mq0.push_back(mk_rd({22'h0, 8'($urandom_range(0, 255)), 2'b00}));
            mq1.push_back(mk_rd({22'h0, 8'($urandom_range(0, 255)), 2'b00}));
        end
        run_phase("t2", 100);
        bad = 0;
        for (int i = 0; i < gseq.size(); i++) if (gseq[i] != (i % 2)) bad++;
        check("t2_grants", gseq.size(), 12);
        check("t2_alternate", bad, 0);
        check("t2_valid_m0", vcnt[0], 6);
        check("t2_valid_m1", vcnt[1], 6);

        // Test 3: fixed priority instance, both masters request continuously
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a1, d1;
            a1 = $urandom; d1 = $urandom;
            @(posedge clk); #1;
            f_s0.read = 1'b1; f_s0.address = $urandom;
            f_s1.write = 1'b1; f_s1.address = a1; f_s1.write_data = d1; f_s1.byte_en = 4'hF;
            @(negedge clk);
            check("fp_ready1", f_s1.request_ready, 1);
            check("fp_ready0", f_s0.request_ready, 0);
            check("fp_addr", f_m.address, a1);
            check("fp_wdata", f_m.write_data, d1);
            check("fp_read", f_m.read, 0);
        end
        @(posedge clk); #1;
        f_s0.read = 1'b0; f_s1.write = 1'b0;

        // Test 4: long latency fills the ID FIFO
        slv_lat = 8; clear_stats();
        for (int i = 0; i < 8; i++) mq0.push_back(mk_rd(32'(i * 4 + 32'h20)));
        run_phase("t4", 200);
        check("t4_max_outstanding", max_out, MAXO);
        check("t4_accepts", n_acc, 8);

        // Test 5: write proceeds while three reads are in flight
        slv_lat = 8; clear_stats();
        for (int i = 0; i < 3; i++) mq0.push_back(mk_rd(32'(32'h10 + i * 4)));
        o = '{0, 0, 32'h0, 4'h0, 32'h0};
        repeat (3) mq1.push_back(o);
        mq1.push_back('{0, 1, 32'h100, 4'b0011, 32'hDEADBEEF});
        mq1.push_back(mk_rd(32'h100));
        run_phase("t5", 200);
        check("t5_write_stalls", wr_stalls, 0);
        check("t5_low_half", {16'h0, last_data[1][15:0]}, 32'h0000BEEF);
        check("t5_word", last_data[1], {init_word(64) >> 16, 16'hBEEF});

        // Test 6: randomized mix with random slave back-pressure
        slv_lat = $urandom_range(1, 5); slv_ready_pct = 70; clear_stats();
        for (int i = 0; i < 40; i++) begin
            for (int m = 0; m < 2; m++) begin
                int k;
                k = $urandom_range(0, 3);
                o.rd = (k == 1 || k == 2); o.wr = (k == 3);
                o.addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                o.be = 4'($urandom); o.wd = $urandom;
                if (m == 0) mq0.push_back(o); else mq1.push_back(o);
            end
        end
        run_phase("t6", 3000);
        check("t6_no_err", err, 0);

        // Test 7: reset with two reads in flight
        slv_lat = 8; slv_ready_pct = 100; clear_stats(); n_drop = 0;
        mq0.push_back(mk_rd(32'h080)); mq0.push_back(mk_rd(32'h084));
        drive_heads();
        n = 0;
        while (mq0.size() > 0 && n < 20) begin step(); n++; end
        @(negedge clk);
        check("t7_in_flight", outstanding, 2);
        do_reset(2);
        n = 0;
        while (rsp_q.size() > 0 && n < 40) begin step(); n++; end
        if (rsp_q.size() > 0) check("t7_timeout", 1, 0);
        step();
        check("t7_err", err, 1);
        check("t7_outstanding", outstanding, 0);
        check("t7_drops", n_drop, 2);
        check("t7_no_valids", vcnt[0] + vcnt[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avl_bus_arbiter.md
Name: avl_bus_arbiter

Overview:
- Two-master to one-slave arbiter on the i_avl_bus interface.
- Lets the instruction-fetch master (core_if) and the data/load-store master share one memory slave (the SDRAM controller, or sdram_sim_model in simulation).
- Arbitrates each request cycle and tracks outstanding pipelined reads in an ID FIFO, so each read_data_valid returns to the master that issued the read.
- Slave is assumed to return read data in order and to give no write responses.

Parameters:
- MAX_OUTSTANDING, 4: depth of the read-ID FIFO; maximum number of reads in flight. Power of 2, at least 2.
- FIXED_PRIO, 0: 0 = round-robin; 1 = master 1 (data) always wins over master 0.

Ports:
- clk  input  1  system clock.
- rest  input  1  reset; asynchronous, active-high.
- avl_s0  i_avl_bus.slave  interface  master 0 port (instruction fetch).
- avl_s1  i_avl_bus.slave  interface  master 1 port (data).
- avl_m0  i_avl_bus.master  interface  to the shared memory slave.
- outstanding  output  $clog2(MAX_OUTSTANDING+1)  number of reads in flight.
- err_unexpected_rsp  output  1  sticky flag: a read_data_valid arrived while the ID FIFO was empty.

Behaviour:
- Reset values: rr_last=1 (so master 0 is preferred first), ID FIFO empty, outstanding=0, err_unexpected_rsp=0.
- While rest=1, avl_m0.read/write=0, both request_ready=0 and both read_data_valid=0.
- A master requests when read|write is high; read and write high together from one master is illegal.
- Grant is combinational, same cycle, with no added latency.
  - Round-robin: if both masters request, grant the master != rr_last. Otherwise grant the sole requester.
  - FIXED_PRIO=1: master 1 wins whenever it requests.
- Forwarding: the granted master's address, byte_en, write_data, read and write drive avl_m0. With no grant, avl_m0.read/write=0 and the other fields come from master 0 (don't-care).
- Accept condition: grant & avl_m0.request_ready & (write | ~fifo_full).
  - Granted master's request_ready = accept; the other master's request_ready = 0.
  - A read with the FIFO full stalls: avl_m0.read is forced 0 that cycle, and the grant still holds that master.
  - A write is never blocked by a full FIFO.
- rr_last updates to the granted ID only on an accepted transfer. A stalled grant does not rotate.
- On an accepted read, push the granted ID (1 bit) into the FIFO.
- Response routing:
  - avl_m0.read_data is broadcast to both masters.
  - read_data_valid goes only to the master at the FIFO head; that entry is popped the same cycle.
  - Response latency through the arbiter is 0 cycles (combinational).
- Push and pop in the same cycle are allowed whenever the FIFO is not full; count is unchanged.
  - When full, a new read is refused even if a pop occurs that cycle. This keeps the read_data_valid to request_ready path free of combinational coupling.
- outstanding = FIFO count; it increments on push, decrements on pop, and never exceeds MAX_OUTSTANDING.
- Unexpected response: read_data_valid with the FIFO empty is dropped (neither master sees valid) and sets err_unexpected_rsp. The flag clears only on reset.
- Reset mid-operation clears the FIFO. Responses still returning from the slave afterwards are dropped and set err_unexpected_rsp; software and bench must treat this as expected.
- FIFO pointers are log2(MAX_OUTSTANDING) bits wide, with natural wrap-around, plus a separate count register of $clog2(MAX_OUTSTANDING+1) bits.

Decomposition:
- Package avl_arb_pkg:
  - typedef logic master_id_t;
  - constants M_IFETCH=1'b0 and M_DATA=1'b1.
- Sub-module avl_arb_id_fifo: synchronous FIFO with parameter DEPTH, master_id_t data, push/pop/full/empty/count, and async active-high rest.
- Arbitration and muxing live in the top module.

Test Plan:
- Master 0 only, reads at 0x000, 0x004, 0x008 back-to-back, slave ready=1 with 1-cycle data latency. Required: 3 accepts in 3 cycles; avl_s0 sees 3 read_data_valid in order with ram words 0-2; avl_s1 sees none.
- Both masters read every cycle, round-robin. Required: grants alternate 0,1,0,1 starting with master 0 after reset; each response returns only to its issuer.
- FIXED_PRIO=1, both request continuously. Required: master 1 granted every cycle; master 0 request_ready stays 0.
- Slave read latency set to 8 cycles, MAX_OUTSTANDING=4, master 0 streams reads. Required: 4 accepts, then request_ready=0 with outstanding=4. Acceptance resumes the cycle after the first pop, not the same cycle.
- Master 1 write 0xDEADBEEF to 0x100 with byte_en=4'b0011 while 3 reads are outstanding. Required: write accepted immediately; a later read of 0x100 returns low half 0xBEEF.
- Reset asserted with 2 reads outstanding, then the slave returns 2 valids after release. Required: both dropped, err_unexpected_rsp=1, outstanding=0.
